delay_slot_arbiter: RTL and testbench
=====================================

// Module: delay_slot_arbiter
// PURPOSE
//  Shares one loadable CNT_W-bit down counter between N_REQ requesters that each need a timed delay.
//  Round-robin arbitration selects one requester, loads its delay value and counts down to zero.
//  At zero the block pulses that requester's done line, then frees the counter for the next request.
//  Sits between requesting FSMs and the shared counter datapath.
// PARAMETERS
//  N_REQ  4  number of requesters (>=2)
//  CNT_W  3  counter / delay width in bits
// PORTS
//  clk          in   1            single clock; all state changes on posedge clk
//  reset_ah_in  in   1            reset, synchronous, active-high
//  req_in       in   N_REQ        level request; held high until done_out or abandoned
//  delay_in     in   N_REQ*CNT_W  packed delays; requester i at [i*CNT_W +: CNT_W]
//  grant_out    out  N_REQ        one-hot owner of the counter; all-zero when idle
//  busy_out     out  1            high while the counter is owned (== |grant_out)
//  count_out    out  CNT_W        current counter value
//  done_out     out  N_REQ        one-cycle pulse to the requester whose count reached 0
// BEHAVIOUR
//  Reset: sampled at posedge clk. The following clear at the next edge, regardless of state:
//   - grant_out=0, busy_out=0, count_out=0, done_out=0
//   - RR pointer=0, state=IDLE
//   Reset mid-RUN aborts the run; no done pulse is issued.
//  States: IDLE, RUN. Encoded as 1 bit.
//  IDLE, any req_in high at edge t:
//   - winner = first requester with req high, searching from pointer upward and wrapping mod N_REQ
//   - at t+1: grant_out = onehot(winner), counter loaded with delay_in[winner], state=RUN
//  RUN, granted requester's req still high:
//   - count != 0: counter decrements by 1 each edge
//   - count == 0: at the next edge done_out[winner]=1 for one cycle, grant_out=0, state=IDLE,
//     pointer = (winner+1) mod N_REQ
//  RUN, granted requester's req low at an edge (abandon):
//   - next edge: state=IDLE, grant_out=0, no done pulse, pointer = winner+1
//   - abandon takes priority over reaching zero
//  Latency for delay D loaded at t+1:
//   - count_out = D at t+1, D-1 at t+2, ..., 0 at t+1+D
//   - done pulse at t+2+D; grant high for D+1 cycles
//  D=0: count_out=0 at t+1, done at t+2.
//  Counter never wraps; decrement is gated off at 0. count_out holds its last value while IDLE.
//  Arbitration is re-evaluated in the same cycle done_out pulses, so back-to-back owners see:
//   - exactly one cycle with grant_out=0 between grants
//   - a new grant at the edge after the done pulse
//  delay_in is sampled only at the grant edge; changes during RUN are ignored.
//  req_in of non-granted requesters has no effect during RUN.
//  Fairness: with all requesters continuously requesting, grants rotate 0,1,2,...,N_REQ-1,0.
//  done_out and grant_out are registered outputs (no combinational path from req_in).
// STRUCTURE
//  Shared header delay_arb_defs.vh: state encodings (ST_IDLE, ST_RUN) and default widths.
//  Sub-module counter_down_en #(CNT_W):
//   - inputs: clk, reset_ah_in, load_in, en_in, d_in; output: count_out
//   - sync reset to 0; load has priority over en; decrement by 1'b1 when enabled
//  Top level holds the FSM, RR pointer, winner mux on delay_in and the done/grant registers.
// TESTING
//  1. Reset: assert reset_ah_in for 2 cycles during RUN (D=5) -> next edge grant=0, count=0, no done.
//  2. Single request: req_in=0001, delay0=3 -> grant 0001 one cycle later; count 3,2,1,0;
//     done_out=0001 on the next cycle; grant then 0000.
//  3. D=0: req_in=0100, delay2=0 -> grant 0100 with count 0, done 0100 next cycle.
//  4. Round-robin: req_in=1111, all delays=1 -> grants 0001,0010,0100,1000,0001;
//     exactly one idle cycle between grants.
//  5. Abandon: req1 granted with D=7, drop req1 when count=4 -> IDLE next edge, no done,
//     a pending req2 is granted next.
//  6. Delay change: granted with delay3=6, change delay3 to 2 mid-run -> still 7 count cycles
//     (6 down to 0), then done.

Source files
------------

// File: rtl/delay_slot_arbiter_pkg.sv
// Shared definitions for the delay slot arbiter: FSM state encoding and
// default parameter values.
package delay_slot_arbiter_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_CNT_W = 3;

  // One-bit state encoding: idle waiting for a request, or counting for an owner.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/delay_slot_arbiter_counter.sv
// Loadable down counter shared by all requesters. Load wins over enable and
// the count sticks at zero instead of wrapping.
module counter_down_en #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_ah_in,
  input  logic             load_in,
  input  logic             en_in,
  input  logic [CNT_W-1:0] d_in,
  output logic [CNT_W-1:0] count_out
);

  logic [CNT_W-1:0] count_reg;

  // Counter register: reset, load, or gated decrement.
  always_ff @(posedge clk) begin
    if (reset_ah_in) begin
      count_reg <= '0;
    end else if (load_in) begin
      count_reg <= d_in;
    end else if (en_in && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count_out = count_reg;

endmodule

// File: rtl/delay_slot_arbiter.sv
// Round-robin arbiter that hands one shared down counter to N_REQ
// requesters, counts the winner's delay to zero and pulses its done line.
module delay_slot_arbiter
  import delay_slot_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset_ah_in,
  input  logic [N_REQ-1:0]       req_in,
  input  logic [N_REQ*CNT_W-1:0] delay_in,
  output logic [N_REQ-1:0]       grant_out,
  output logic                   busy_out,
  output logic [CNT_W-1:0]       count_out,
  output logic [N_REQ-1:0]       done_out
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  arb_state_t       state_reg, state_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [PTR_W-1:0] owner_reg, owner_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic [N_REQ-1:0] done_reg, done_next;

  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] ptr_after;
  logic             owner_req;
  logic             count_zero;
  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_value;

  // Pick the first requesting index at or after the pointer, wrapping around.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] cand;
    found  = 1'b0;
    winner = ptr_reg;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((int'(ptr_reg) + k) % N_REQ);
      if (!found && req_in[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign owner_req  = req_in[owner_reg];
  assign count_zero = (cnt_value == '0);
  assign ptr_after  = (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset_ah_in) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: start on any request, leave RUN on abandon or reaching zero.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (|req_in) state_next = ST_RUN;
      ST_RUN:  if (!owner_req || count_zero) state_next = ST_IDLE;
    endcase
  end

  // Output/datapath control: counter load/enable, next grant, done and pointer.
  always_comb begin
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    grant_next = '0;
    done_next  = '0;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|req_in) begin
          cnt_load   = 1'b1;
          owner_next = winner;
          grant_next = ONE_HOT0 << winner;
        end
      end
      ST_RUN: begin
        if (!owner_req) begin
          // Abandon outranks reaching zero: no done pulse.
          ptr_next = ptr_after;
        end else if (count_zero) begin
          done_next = ONE_HOT0 << owner_reg;
          ptr_next  = ptr_after;
        end else begin
          cnt_en     = 1'b1;
          grant_next = grant_reg;
        end
      end
    endcase
  end

  // Registered grant/done outputs, round-robin pointer and current owner.
  always_ff @(posedge clk) begin
    if (reset_ah_in) begin
      ptr_reg   <= '0;
      owner_reg <= '0;
      grant_reg <= '0;
      done_reg  <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      grant_reg <= grant_next;
      done_reg  <= done_next;
    end
  end

  counter_down_en #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk        (clk),
    .reset_ah_in(reset_ah_in),
    .load_in    (cnt_load),
    .en_in      (cnt_en),
    .d_in       (delay_in[winner*CNT_W +: CNT_W]),
    .count_out  (cnt_value)
  );

  assign grant_out = grant_reg;
  assign busy_out  = |grant_reg;
  assign count_out = cnt_value;
  assign done_out  = done_reg;

endmodule

// File: tb/tb_delay_slot_arbiter.sv
// Scoreboard bench for delay_slot_arbiter: the driver applies stimulus on the
// falling edge and pushes the expected post-edge outputs from a simple
// behavioural model; a monitor pops and compares just after each rising edge.
module tb_delay_slot_arbiter;

  localparam int N = 4;
  localparam int W = 3;

  logic           clk;
  logic           reset_ah_in;
  logic [N-1:0]   req_in;
  logic [N*W-1:0] delay_in;
  logic [N-1:0]   grant_out;
  logic           busy_out;
  logic [W-1:0]   count_out;
  logic [N-1:0]   done_out;

  delay_slot_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
    .clk        (clk),
    .reset_ah_in(reset_ah_in),
    .req_in     (req_in),
    .delay_in   (delay_in),
    .grant_out  (grant_out),
    .busy_out   (busy_out),
    .count_out  (count_out),
    .done_out   (done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grant;
    logic [W-1:0] cnt;
    logic [N-1:0] done;
    logic         busy;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference model: owner index (-1 when idle), remaining count, pointer.
  int   m_owner = -1;
  int   m_cnt   = 0;
  int   m_ptr   = 0;
  int   m_done  = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  // Apply one cycle of inputs, predict the outputs after the next rising edge.
  task automatic step(input logic r, input logic [N-1:0] q, input logic [N*W-1:0] d);
    exp_t e;
    int   w;
    reset_ah_in = r;
    req_in      = q;
    delay_in    = d;
    if (r) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_done = 0;
    end else if (m_owner < 0) begin
      m_done = 0;
      if (q != '0) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && q[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        m_owner = w;
        m_cnt   = int'(d[w*W +: W]);
      end
    end else if (!q[m_owner]) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_done = 0;
    end else if (m_cnt == 0) begin
      m_done = 1 << m_owner; m_ptr = (m_owner + 1) % N; m_owner = -1;
    end else begin
      m_cnt = m_cnt - 1; m_done = 0;
    end
    e.grant = (m_owner < 0) ? '0 : N'(1 << m_owner);
    e.busy  = (m_owner >= 0);
    e.cnt   = W'(m_cnt);
    e.done  = N'(m_done);
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  function automatic logic [N*W-1:0] dl(input int d0, input int d1, input int d2, input int d3);
    return {W'(d3), W'(d2), W'(d1), W'(d0)};
  endfunction

  // Monitor: compare DUT outputs against the oldest expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("grant", int'(grant_out), int'(e.grant));
        chk("count", int'(count_out), int'(e.cnt));
        chk("done",  int'(done_out),  int'(e.done));
        chk("busy",  int'(busy_out),  int'(e.busy));
      end
    end
  end

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    logic [N-1:0]   rq;
    logic [N*W-1:0] dv;
    logic           rr;
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    // Reset during a D=5 run aborts without a done pulse.
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0001, dl(5, 0, 0, 0));
    step(1'b1, 4'b0001, dl(5, 0, 0, 0));
    step(1'b1, 4'b0001, dl(5, 0, 0, 0));
    step(1'b0, 4'b0000, '0);
    // Single request, delay 3.
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0001, dl(3, 0, 0, 0));
    for (int i = 0; i < 2; i++) step(1'b0, 4'b0000, '0);
    // Zero delay on requester 2.
    for (int i = 0; i < 2; i++) step(1'b0, 4'b0100, dl(0, 0, 0, 0));
    for (int i = 0; i < 2; i++) step(1'b0, 4'b0000, '0);
    // Round-robin with everybody requesting and delay 1.
    step(1'b1, '0, '0);
    for (int i = 0; i < 16; i++) step(1'b0, 4'b1111, dl(1, 1, 1, 1));
    step(1'b1, '0, '0);
    // Abandon: requester 1 drops out at count 4, requester 2 takes over.
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0110, dl(0, 7, 2, 0));
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0100, dl(0, 7, 2, 0));
    step(1'b1, '0, '0);
    // Delay change mid-run is ignored.
    step(1'b0, 4'b1000, dl(0, 0, 0, 6));
    for (int i = 0; i < 7; i++) step(1'b0, 4'b1000, dl(0, 0, 0, 2));
    for (int i = 0; i < 2; i++) step(1'b0, 4'b0000, '0);
    // Randomized traffic.
    rq = '0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0) rq[$urandom_range(0, N-1)] ^= 1'b1;
      dv = (N*W)'($urandom);
      rr = ($urandom_range(0, 199) == 0);
      step(rr, rq, dv);
    end
    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) chk("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
